// File: rtl/controlador_mult_flotante.sv
// Sequential multiplier for the 16-bit {sign, exp[6:0], mant[7:0]} format:
// accept -> multiply mantissas -> normalize/saturate -> hold result until taken.
module controlador_mult_flotante #(
    parameter int BIAS = 63
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_operando_1,
    input  logic [15:0] i_operando_2,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_resultado,
    output logic        o_overflow,
    output logic        o_underflow,
    output logic [7:0]  o_cuenta_ops
);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        op1_q, op1_d, op2_q, op2_d;
    logic [17:0]        prod_q, prod_d;
    logic signed [8:0]  exp_q, exp_d;
    logic               ready_q, ready_d, valid_q, valid_d;
    logic [15:0]        res_q, res_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               sign_r, zero_op, inf_op;
    logic signed [9:0]  exp_norm;
    logic [7:0]         mant_norm;
    logic               unused_prod_lsbs;

    assign unused_prod_lsbs = ^prod_q[7:0];

    always_comb begin
        sign_r    = op1_q[15] ^ op2_q[15];
        zero_op   = (op1_q[14:8] == 7'h00) || (op2_q[14:8] == 7'h00);
        inf_op    = (op1_q[14:8] == 7'h7F) || (op2_q[14:8] == 7'h7F);
        // A carry out of the integer bit means the product is in [2,4): shift and bump the exponent.
        exp_norm  = {exp_q[8], exp_q} + {9'd0, prod_q[17]};
        mant_norm = prod_q[17] ? prod_q[16:9] : prod_q[15:8];
    end

    always_comb begin
        // NOTE: every _d defaults to its _q so no path can leave a variable unassigned and infer a latch.
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        prod_d  = prod_q;
        exp_d   = exp_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    op1_d   = i_operando_1;
                    op2_d   = i_operando_2;
                    state_d = MULT;
                end
            end
            MULT: begin
                prod_d  = {9'd0, 1'b1, op1_q[7:0]} * {9'd0, 1'b1, op2_q[7:0]};
                exp_d   = {2'b00, op1_q[14:8]} + {2'b00, op2_q[14:8]} - 9'(BIAS);
                state_d = NORM;
            end
            NORM: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                // Zero operands win over infinities; then range saturation.
                if (zero_op) begin
                    res_d = {sign_r, 15'h0000};
                end else if (inf_op || exp_norm >= 10'sd127) begin
                    res_d = {sign_r, 7'h7F, 8'h00};
                    ovf_d = 1'b1;
                end else if (exp_norm <= 10'sd0) begin
                    res_d = {sign_r, 15'h0000};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign_r, exp_norm[6:0], mant_norm};
                end
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            prod_q  <= '0;
            exp_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            prod_q  <= prod_d;
            exp_q   <= exp_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_resultado  = res_q;
    assign o_overflow   = ovf_q;
    assign o_underflow  = unf_q;
    assign o_cuenta_ops = cnt_q;

endmodule
